// File: rtl/mips_reg_pkg.sv
// rtl/mips_reg_pkg.sv - register file widths and MIPS ABI register indices
//
// Purpose: default data/index widths for the register file and named
//          register indices in MIPS ABI order.
// Ports:   none (package).

package mips_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_AT   = 5'd1;
    localparam reg_idx_t REG_V0   = 5'd2;
    localparam reg_idx_t REG_V1   = 5'd3;
    localparam reg_idx_t REG_A0   = 5'd4;
    localparam reg_idx_t REG_A1   = 5'd5;
    localparam reg_idx_t REG_A2   = 5'd6;
    localparam reg_idx_t REG_A3   = 5'd7;
    localparam reg_idx_t REG_T0   = 5'd8;
    localparam reg_idx_t REG_T1   = 5'd9;
    localparam reg_idx_t REG_T2   = 5'd10;
    localparam reg_idx_t REG_T3   = 5'd11;
    localparam reg_idx_t REG_T4   = 5'd12;
    localparam reg_idx_t REG_T5   = 5'd13;
    localparam reg_idx_t REG_T6   = 5'd14;
    localparam reg_idx_t REG_T7   = 5'd15;
    localparam reg_idx_t REG_S0   = 5'd16;
    localparam reg_idx_t REG_S1   = 5'd17;
    localparam reg_idx_t REG_S2   = 5'd18;
    localparam reg_idx_t REG_S3   = 5'd19;
    localparam reg_idx_t REG_S4   = 5'd20;
    localparam reg_idx_t REG_S5   = 5'd21;
    localparam reg_idx_t REG_S6   = 5'd22;
    localparam reg_idx_t REG_S7   = 5'd23;
    localparam reg_idx_t REG_T8   = 5'd24;
    localparam reg_idx_t REG_T9   = 5'd25;
    localparam reg_idx_t REG_K0   = 5'd26;
    localparam reg_idx_t REG_K1   = 5'd27;
    localparam reg_idx_t REG_GP   = 5'd28;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_FP   = 5'd30;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port with write-first bypass
//
// Purpose: selects one register from the flattened register array, forwards
//          same-cycle write data on an address match, and registers the
//          result with a valid strobe one cycle after the request.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          re, raddr     - read request and register index
//          regs          - all registers, index 0 lowest, entry 0 is zero
//          we, waddr,
//          wdata         - write port of the same cycle, used for bypass
//          rdata, rvalid - registered read data and its valid strobe

module regfile_read_port
    import mips_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 re,
    input  logic [ADDR_W-1:0]                    raddr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic                                 we,
    input  logic [ADDR_W-1:0]                    waddr,
    input  logic [DATA_W-1:0]                    wdata,
    output logic [DATA_W-1:0]                    rdata,
    output logic                                 rvalid
);

    logic [DATA_W-1:0] sel;

    // Bypass before the zero override: a write to index 0 must never leak
    // into a read of index 0.
    always_comb begin
        sel = regs[raddr];
        if (we && (waddr == raddr)) begin
            sel = wdata;
        end
        if (raddr == '0) begin
            sel = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= sel;
            end
        end
    end

endmodule

// File: rtl/regfile_read.sv
// rtl/regfile_read.sv - 32-entry MIPS register file, one write and two read ports
//
// Purpose: holds registers 1..31 (register 0 is hard-wired to zero), decodes
//          writes, and feeds two independent registered read ports.
// Ports:   clk, rst                     - clock, synchronous active-high reset
//          we, waddr, wdata             - write strobe, index, data
//          re_a, raddr_a, rdata_a,
//          rvalid_a                     - read port A
//          re_b, raddr_b, rdata_b,
//          rvalid_b                     - read port B

module regfile_read
    import mips_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    localparam int NREGS = 1 << ADDR_W;

    // Only entries 1..NREGS-1 are storage; entry 0 is a constant zero.
    logic [NREGS-1:1][DATA_W-1:0] store;
    logic [NREGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (rst) begin
                store[i] <= '0;
            end else if (we && (waddr == ADDR_W'(i))) begin
                store[i] <= wdata;
            end
        end
    end

    assign regs = {store, {DATA_W{1'b0}}};

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .clk    (clk),
        .rst    (rst),
        .re     (re_a),
        .raddr  (raddr_a),
        .regs   (regs),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_a),
        .rvalid (rvalid_a)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .clk    (clk),
        .rst    (rst),
        .re     (re_b),
        .raddr  (raddr_b),
        .regs   (regs),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_b),
        .rvalid (rvalid_b)
    );

endmodule
